// File: rtl/tank_pio_pkg.sv
// Shared types and constants for the motor-direction PIO write arbiter.
// Dead-time support is enabled with the PIO_ARB_DEADTIME_EN macro.
package tank_pio_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WR_OFF = 2'd1,
        DEAD   = 2'd2,
        WR_VAL = 2'd3
    } pio_state_e;

    localparam logic [1:0] PIO_DATA_ADDR = 2'd0;
    localparam int DEFAULT_DEAD_CYCLES = 16;

endpackage

// File: rtl/tank_rr_arb2.sv
// Two-way round-robin arbiter; last_grant resets to 1 so req0 wins the first tie.
// Grant history only advances when the owner accepts the granted request.
module tank_rr_arb2
    import tank_pio_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] valid,
    input  logic       accept,
    output logic [1:0] grant,
    output logic       last_grant
);

    logic r_last_grant;

    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = r_last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_grant <= 1'b1;
        end else if (accept) begin
            r_last_grant <= grant[1];
        end
    end

    assign last_grant = r_last_grant;

endmodule

// File: rtl/tank_pio_write_arbiter.sv
// Arbitrates two requesters onto the motor PIO, skipping redundant writes.
// Define PIO_ARB_DEADTIME_EN to insert an all-off hold before reversals.
module tank_pio_write_arbiter
    import tank_pio_pkg::*;
#(
    parameter int DATA_W      = 4,
    parameter int DEAD_CYCLES = DEFAULT_DEAD_CYCLES,
    parameter int CNT_W       = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic [1:0]        avm_address,
    output logic              avm_chipselect,
    output logic              avm_write_n,
    output logic [31:0]       avm_writedata,
    output logic [DATA_W-1:0] shadow,
    output logic              busy
);

    pio_state_e        r_state;
    logic              r_cs;
    logic              r_wn;
    logic [31:0]       r_wd;
    logic [DATA_W-1:0] r_shadow;
    logic [DATA_W-1:0] r_data;

    logic [1:0]        w_valid;
    logic [1:0]        w_grant;
    logic              w_idle;
    logic              w_accept;
    logic              w_last_grant;
    logic              w_need_dead;
    logic [DATA_W-1:0] w_data;
    logic [31:0]       w_unused_cfg;

    assign w_valid  = {req1_valid, req0_valid};
    assign w_idle   = (r_state == IDLE);
    assign w_accept = w_idle & (|w_valid);
    assign w_data   = w_grant[1] ? req1_data : req0_data;

    tank_rr_arb2 u_arb (
        .clk        (clk),
        .reset      (reset),
        .valid      (w_valid),
        .accept     (w_accept),
        .grant      (w_grant),
        .last_grant (w_last_grant)
    );

`ifdef PIO_ARB_DEADTIME_EN
    logic [CNT_W-1:0] r_cnt;

    // Reversal between two different non-zero directions must pass through 0
    assign w_need_dead = (r_shadow != '0) && (w_data != '0)
                      && (w_data != r_shadow);
    assign w_unused_cfg = {31'b0, w_last_grant};
`else
    assign w_need_dead  = 1'b0;
    assign w_unused_cfg = 32'(DEAD_CYCLES) ^ 32'(CNT_W)
                        ^ {31'b0, w_last_grant};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_cs     <= 1'b0;
            r_wn     <= 1'b1;
            r_wd     <= '0;
            r_shadow <= '0;
            r_data   <= '0;
`ifdef PIO_ARB_DEADTIME_EN
            r_cnt    <= '0;
`endif
        end else begin
            r_cs <= 1'b0;
            r_wn <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (w_accept && (w_data != r_shadow)) begin
                        r_data <= w_data;
                        r_cs   <= 1'b1;
                        r_wn   <= 1'b0;
                        if (w_need_dead) begin
                            r_wd    <= '0;
                            r_state <= WR_OFF;
                        end else begin
                            r_wd    <= 32'(w_data);
                            r_state <= WR_VAL;
                        end
                    end
                end
`ifdef PIO_ARB_DEADTIME_EN
                WR_OFF: begin
                    r_shadow <= '0;
                    r_cnt    <= CNT_W'(DEAD_CYCLES);
                    r_state  <= DEAD;
                end
                DEAD: begin
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CNT_W'(1)) begin
                        r_cs    <= 1'b1;
                        r_wn    <= 1'b0;
                        r_wd    <= 32'(r_data);
                        r_state <= WR_VAL;
                    end
                end
`endif
                WR_VAL: begin
                    r_shadow <= r_data;
                    r_state  <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req0_ready     = w_idle & w_grant[0] & req0_valid;
    assign req1_ready     = w_idle & w_grant[1] & req1_valid;
    assign avm_address    = PIO_DATA_ADDR;
    assign avm_chipselect = r_cs;
    assign avm_write_n    = r_wn;
    assign avm_writedata  = r_wd;
    assign shadow         = r_shadow;
    assign busy           = ~w_idle;

endmodule

// File: tb/tb_tank_pio_write_arbiter.sv
// Self-checking bench for tank_pio_write_arbiter: vector table, directed
// corner sequences and a randomized run against a timeline reference model.
module tb_tank_pio_write_arbiter;

    localparam int D = 16;
`ifdef PIO_ARB_DEADTIME_EN
    localparam bit DT = 1'b1;
`else
    localparam bit DT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid;
    logic [3:0]  req0_data;
    logic        req0_ready;
    logic        req1_valid;
    logic [3:0]  req1_data;
    logic        req1_ready;
    logic [1:0]  avm_address;
    logic        avm_chipselect;
    logic        avm_write_n;
    logic [31:0] avm_writedata;
    logic [3:0]  shadow;
    logic        busy;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    tank_pio_write_arbiter #(
        .DATA_W      (4),
        .DEAD_CYCLES (D),
        .CNT_W       (8)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req0_valid     (req0_valid),
        .req0_data      (req0_data),
        .req0_ready     (req0_ready),
        .req1_valid     (req1_valid),
        .req1_data      (req1_data),
        .req1_ready     (req1_ready),
        .avm_address    (avm_address),
        .avm_chipselect (avm_chipselect),
        .avm_write_n    (avm_write_n),
        .avm_writedata  (avm_writedata),
        .shadow         (shadow),
        .busy           (busy)
    );

    typedef struct {
        logic       v0;
        logic [3:0] d0;
        logic       v1;
        logic [3:0] d1;
        logic       r0;
        logic       r1;
        logic       cs;
        logic [3:0] wd;
        logic       bsy;
        logic [3:0] sh;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic drive(input logic v0, input logic [3:0] d0,
                         input logic v1, input logic [3:0] d1);
        req0_valid = v0;
        req0_data  = d0;
        req1_valid = v1;
        req1_data  = d1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b0, 4'h0, 1'b0, 4'h0);
        nxt();
        nxt();
        reset = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int k;
        for (k = 0; k < 60; k++) begin
            smp();
            if (busy === 1'b0) break;
            nxt();
        end
        if (k == 60) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s: busy stuck got 1 want 0", nm);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl[12];
        int   last;
        int   m_last;
        int   bu;
        int   g;
        bit   idle;
        bit   ecs;
        bit   pv[2];
        logic [3:0] pd[2];
        logic [3:0] m_sh;
        logic [3:0] m_wd;
        logic [3:0] wr[int];
        logic [3:0] d;

        //         v0 d0   v1 d1   r0 r1 cs wd   bsy sh
        tbl[0]  = '{1, 4'h5, 1, 4'h5, 1, 0, 0, 4'h0, 0, 4'h0};
        tbl[1]  = '{0, 4'h0, 1, 4'h5, 0, 0, 1, 4'h5, 1, 4'h0};
        tbl[2]  = '{0, 4'h0, 1, 4'h5, 0, 1, 0, 4'h5, 0, 4'h5};
        tbl[3]  = '{1, 4'h0, 1, 4'h0, 1, 0, 0, 4'h5, 0, 4'h5};
        tbl[4]  = '{0, 4'h0, 1, 4'h0, 0, 0, 1, 4'h0, 1, 4'h5};
        tbl[5]  = '{0, 4'h0, 1, 4'h0, 0, 1, 0, 4'h0, 0, 4'h0};
        tbl[6]  = '{1, 4'h7, 1, 4'h7, 1, 0, 0, 4'h0, 0, 4'h0};
        tbl[7]  = '{0, 4'h0, 1, 4'h7, 0, 0, 1, 4'h7, 1, 4'h0};
        tbl[8]  = '{1, 4'h0, 1, 4'h7, 0, 1, 0, 4'h7, 0, 4'h7};
        tbl[9]  = '{1, 4'h0, 0, 4'h0, 1, 0, 0, 4'h7, 0, 4'h7};
        tbl[10] = '{0, 4'h0, 0, 4'h0, 0, 0, 1, 4'h0, 1, 4'h7};
        tbl[11] = '{0, 4'h0, 0, 4'h0, 0, 0, 0, 4'h0, 0, 4'h0};

        // reset state
        do_reset();
        smp();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_cs", 32'(avm_chipselect), 0);
        chk("rst_wn", 32'(avm_write_n), 1);
        chk("rst_addr", 32'(avm_address), 0);
        chk("rst_wd", avm_writedata, 0);
        chk("rst_shadow", 32'(shadow), 0);
        chk("rst_r0", 32'(req0_ready), 0);
        chk("rst_r1", 32'(req1_ready), 0);

        // arbitration / skip table
        for (int i = 0; i < 12; i++) begin
            nxt();
            drive(tbl[i].v0, tbl[i].d0, tbl[i].v1, tbl[i].d1);
            smp();
            chk($sformatf("tbl%0d_r0", i), 32'(req0_ready), 32'(tbl[i].r0));
            chk($sformatf("tbl%0d_r1", i), 32'(req1_ready), 32'(tbl[i].r1));
            chk($sformatf("tbl%0d_cs", i), 32'(avm_chipselect), 32'(tbl[i].cs));
            chk($sformatf("tbl%0d_wn", i), 32'(avm_write_n), 32'(!tbl[i].cs));
            chk($sformatf("tbl%0d_wd", i), avm_writedata, 32'(tbl[i].wd));
            chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].bsy));
            chk($sformatf("tbl%0d_sh", i), 32'(shadow), 32'(tbl[i].sh));
        end

        // first write after reset
        do_reset();
        drive(1'b1, 4'h5, 1'b0, 4'h0);
        smp();
        chk("h1_r0", 32'(req0_ready), 1);
        nxt();
        drive(1'b0, 4'h0, 1'b0, 4'h0);
        smp();
        chk("h1_cs", 32'(avm_chipselect), 1);
        chk("h1_wd", avm_writedata, 32'h5);
        nxt();
        smp();
        chk("h1_cs_off", 32'(avm_chipselect), 0);
        chk("h1_shadow", 32'(shadow), 5);

        // reversal 5 -> A
        nxt();
        drive(1'b0, 4'h0, 1'b1, 4'hA);
        smp();
        chk("h2_r1", 32'(req1_ready), 1);
        last = DT ? D + 2 : 1;
        for (int k = 1; k <= last; k++) begin
            nxt();
            drive(1'b0, 4'h0, 1'b0, 4'h0);
            smp();
            chk($sformatf("h2_cs_k%0d", k), 32'(avm_chipselect),
                32'((k == last) || (DT && k == 1)));
            chk($sformatf("h2_wd_k%0d", k), avm_writedata,
                (k == last) ? 32'hA : 32'h0);
            chk($sformatf("h2_busy_k%0d", k), 32'(busy), 1);
            if (DT && k == 5) chk("h2_dead_shadow", 32'(shadow), 0);
        end
        nxt();
        smp();
        chk("h2_shadow", 32'(shadow), 32'hA);
        chk("h2_idle", 32'(busy), 0);

        // equal value is skipped, next accept one cycle later
        nxt();
        drive(1'b1, 4'hA, 1'b0, 4'h0);
        smp();
        chk("h3_r0", 32'(req0_ready), 1);
        nxt();
        drive(1'b0, 4'h0, 1'b1, 4'h0);
        smp();
        chk("h3_no_cs", 32'(avm_chipselect), 0);
        chk("h3_no_busy", 32'(busy), 0);
        chk("h3_r1_next", 32'(req1_ready), 1);
        nxt();
        drive(1'b0, 4'h0, 1'b0, 4'h0);
        smp();
        chk("h3_cs0", 32'(avm_chipselect), 1);
        chk("h3_wd0", avm_writedata, 0);
        nxt();
        smp();
        chk("h3_shadow", 32'(shadow), 0);

        // reset mid-sequence
        nxt();
        drive(1'b1, 4'h5, 1'b0, 4'h0);
        nxt();
        drive(1'b0, 4'h0, 1'b0, 4'h0);
        wait_idle("h4_pre");
        nxt();
        drive(1'b0, 4'h0, 1'b1, 4'hA);
        smp();
        chk("h4_r1", 32'(req1_ready), 1);
        nxt();
        drive(1'b0, 4'h0, 1'b0, 4'h0);
        if (DT) repeat (3) nxt();
        reset = 1'b1;
        nxt();
        reset = 1'b0;
        smp();
        chk("h4_busy", 32'(busy), 0);
        chk("h4_shadow", 32'(shadow), 0);
        chk("h4_cs", 32'(avm_chipselect), 0);
        chk("h4_wn", 32'(avm_write_n), 1);
        nxt();
        drive(1'b1, 4'h9, 1'b0, 4'h0);
        smp();
        chk("h4_r0", 32'(req0_ready), 1);
        nxt();
        drive(1'b0, 4'h0, 1'b0, 4'h0);
        smp();
        chk("h4_cs9", 32'(avm_chipselect), 1);
        chk("h4_wd9", avm_writedata, 32'h9);
        nxt();
        smp();
        chk("h4_shadow9", 32'(shadow), 9);

        // randomized run against the timeline model
        do_reset();
        m_last = 1;
        bu     = -1;
        m_sh   = '0;
        m_wd   = '0;
        pv[0]  = 1'b0;
        pv[1]  = 1'b0;
        pd[0]  = '0;
        pd[1]  = '0;
        wr.delete();
        for (int c = 0; c < 800; c++) begin
            if (c > 0) nxt();
            for (int i = 0; i < 2; i++) begin
                if (!pv[i] && $urandom_range(0, 2) == 0) begin
                    pv[i] = 1'b1;
                    if ($urandom_range(0, 3) == 0) pd[i] = m_sh;
                    else pd[i] = 4'($urandom_range(0, 15));
                end
            end
            drive(pv[0], pd[0], pv[1], pd[1]);
            idle = (c > bu);
            g = -1;
            if (idle) begin
                if (pv[0] && (!pv[1] || m_last == 1)) g = 0;
                else if (pv[1]) g = 1;
            end
            ecs = wr.exists(c);
            if (ecs) m_wd = wr[c];
            smp();
            chk("rnd_r0", 32'(req0_ready), 32'(g == 0));
            chk("rnd_r1", 32'(req1_ready), 32'(g == 1));
            chk("rnd_cs", 32'(avm_chipselect), 32'(ecs));
            chk("rnd_wn", 32'(avm_write_n), 32'(!ecs));
            chk("rnd_wd", avm_writedata, 32'(m_wd));
            chk("rnd_busy", 32'(busy), 32'(!idle));
            if (idle) chk("rnd_shadow", 32'(shadow), 32'(m_sh));
            if (g >= 0) begin
                m_last = g;
                pv[g]  = 1'b0;
                d      = pd[g];
                if (d != m_sh) begin
                    if (DT && m_sh != 0 && d != 0) begin
                        wr[c + 1]     = 4'h0;
                        wr[c + 2 + D] = d;
                        bu            = c + 2 + D;
                    end else begin
                        wr[c + 1] = d;
                        bu        = c + 1;
                    end
                    m_sh = d;
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
